// File: rtl/i3c_pkg.sv
// i3c_pkg: types and constants shared by the I3C target-side IBI logic.
//   ibi_status_e  outcome codes written to LAST_IBI_STATUS
//   ibi_desc_t    latched IBI descriptor (mandatory data byte + payload length)
//   IbiMdbOffset  bit position of the MDB within a descriptor word
//   IbiLenWidth   width of the payload length field (bits [IbiLenWidth-1:0])
package i3c_pkg;

  localparam int IbiMdbOffset = 24;
  localparam int IbiLenWidth  = 8;

  typedef enum logic [1:0] {
    IbiStsOk       = 2'b00,
    IbiStsNacked   = 2'b01,
    IbiStsAborted  = 2'b10,
    IbiStsDisabled = 2'b11
  } ibi_status_e;

  typedef struct packed {
    logic [7:0]             mdb;
    logic [IbiLenWidth-1:0] len;
  } ibi_desc_t;

endpackage

// File: rtl/ibi_byte_serializer.sv
// ibi_byte_serializer: turns IBI payload words into a valid/ready byte stream.
// A word is loaded into a shift buffer and sent least significant byte first.
// Only the bytes still owed for the current IBI are counted as valid, so the
// unused upper bytes of the final word are never presented.
//   start_i      begin a new IBI: take the byte count from len_i, empty buffer
//   len_i        payload byte count of the new IBI
//   load_i       capture word_i into the shift buffer (only when need_word_o)
//   word_i       payload word from the queue
//   clear_i      discard the buffered bytes (abort)
//   ready_i      downstream accepts byte_o
//   byte_o       current byte; valid_o while the buffer holds bytes
//   last_o       current byte is the final payload byte
//   need_word_o  buffer is empty, or empties with this cycle's handshake
module ibi_byte_serializer #(
  parameter int unsigned IbiDataWidth = 32,
  parameter int unsigned LenWidth     = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [LenWidth-1:0]     len_i,
  input  logic                    load_i,
  input  logic [IbiDataWidth-1:0] word_i,
  input  logic                    clear_i,
  input  logic                    ready_i,
  output logic [7:0]              byte_o,
  output logic                    valid_o,
  output logic                    last_o,
  output logic                    need_word_o
);

  localparam int unsigned Bpw  = IbiDataWidth / 8;
  localparam int unsigned CntW = $clog2(Bpw + 1);

  logic [IbiDataWidth-1:0] shift_q;
  logic [CntW-1:0]         cnt_q;      // bytes left in the shift buffer
  logic [LenWidth-1:0]     left_q;     // bytes left in the whole IBI
  logic [LenWidth-1:0]     left_after;
  logic                    handshake;

  assign valid_o     = (cnt_q != '0);
  assign byte_o      = shift_q[7:0];
  assign handshake   = valid_o && ready_i;
  assign last_o      = valid_o && (left_q == LenWidth'(1));
  assign need_word_o = (cnt_q == '0) || ((cnt_q == CntW'(1)) && handshake);
  assign left_after  = handshake ? left_q - LenWidth'(1) : left_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      cnt_q   <= '0;
      left_q  <= '0;
    end else if (start_i) begin
      left_q <= len_i;
      cnt_q  <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else begin
      left_q <= left_after;
      if (load_i) begin
        // Loading in the cycle the previous word's last byte goes keeps the
        // stream gap-free across word boundaries.
        shift_q <= word_i;
        cnt_q   <= (left_after >= LenWidth'(Bpw)) ? CntW'(Bpw) : CntW'(left_after);
      end else if (handshake) begin
        shift_q <= shift_q >> 8;
        cnt_q   <= cnt_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/tti_ibi_sequencer.sv
// tti_ibi_sequencer: target-side In-Band Interrupt sequencer.
// Pops an IBI descriptor (MDB in [31:24], LEN in [7:0]) and its payload words
// from the TTI IBI queue, requests the IBI from the target bus FSM, retries on
// NACK, streams the payload bytes and writes the outcome to LAST_IBI_STATUS.
// Optional feature: define I3C_IBI_RETRY_EN to enable NACK retries with a
// RetryDelay-cycle backoff; otherwise the first NACK ends the IBI.
// Ports:
//   ibi_queue_empty_i/rdata_i/rd_o  first-word fall-through IBI queue read side
//   ibi_en_i                        CONTROL.IBI_EN
//   ibi_req_o, ibi_mdb_o            IBI request and its mandatory data byte
//   ibi_ack_i, ibi_nack_i           controller response to the IBI address
//   ibi_byte_o/valid_o/last_o       payload byte stream, ibi_byte_ready_i
//   ibi_abort_i                     controller ended the read early
//   ibi_status_o, ibi_status_we_o   LAST_IBI_STATUS value and write strobe
//   busy_o                          an IBI is in progress
module tti_ibi_sequencer
  import i3c_pkg::*;
#(
  parameter int unsigned IbiDataWidth = 32,
  parameter int unsigned MaxRetries   = 3,
  parameter int unsigned RetryDelay   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    ibi_queue_empty_i,
  input  logic [IbiDataWidth-1:0] ibi_queue_rdata_i,
  output logic                    ibi_queue_rd_o,
  input  logic                    ibi_en_i,
  output logic                    ibi_req_o,
  output logic [7:0]              ibi_mdb_o,
  input  logic                    ibi_ack_i,
  input  logic                    ibi_nack_i,
  output logic [7:0]              ibi_byte_o,
  output logic                    ibi_byte_valid_o,
  output logic                    ibi_byte_last_o,
  input  logic                    ibi_byte_ready_i,
  input  logic                    ibi_abort_i,
  output logic [1:0]              ibi_status_o,
  output logic                    ibi_status_we_o,
  output logic                    busy_o
);

  localparam int unsigned Bpw = IbiDataWidth / 8;

`ifdef I3C_IBI_RETRY_EN
  localparam int unsigned RetryW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
  localparam int unsigned DelayW = (RetryDelay > 1) ? $clog2(RetryDelay) : 1;

  typedef enum logic [2:0] {StIdle, StReq, StBackoff, StSend, StDrain, StStatus} state_e;

  logic [RetryW-1:0] retry_cnt_q;
  logic [DelayW-1:0] delay_cnt_q;
`else
  typedef enum logic [2:0] {StIdle, StReq, StSend, StDrain, StStatus} state_e;

  // Retry parameters are accepted so both builds share one interface.
  if ((MaxRetries > 0) || (RetryDelay > 0)) begin : g_retry_params_ignored
  end
`endif

  state_e                 state_q;
  ibi_desc_t              desc_q;
  ibi_desc_t              desc_in;
  logic [IbiLenWidth-1:0] words_left_q;
  logic [IbiLenWidth-1:0] words_in;
  logic [IbiLenWidth:0]   len_round;
  ibi_status_e            status_q;
  logic                   req_q;
  logic                   status_we_q;

  logic pop_start, pop_send, pop_drain;
  logic need_word, byte_hs;

  assign desc_in   = '{mdb: ibi_queue_rdata_i[IbiMdbOffset +: 8],
                       len: ibi_queue_rdata_i[IbiLenWidth-1:0]};
  assign len_round = {1'b0, desc_in.len} + (IbiLenWidth + 1)'(Bpw - 1);
  assign words_in  = IbiLenWidth'(len_round / (IbiLenWidth + 1)'(Bpw));

  // NOTE: the pop strobe is decoded combinationally from state and queue
  // status so it lands in the same cycle as the head word it consumes; a
  // registered strobe would pop one cycle after the word was used.
  assign pop_start = (state_q == StIdle) && !ibi_queue_empty_i && ibi_en_i;
  assign pop_send  = (state_q == StSend) && need_word && (words_left_q != '0) &&
                     !ibi_queue_empty_i;
  assign pop_drain = (state_q == StDrain) && (words_left_q != '0) && !ibi_queue_empty_i;
  assign ibi_queue_rd_o = pop_start || pop_send || pop_drain;

  assign byte_hs         = ibi_byte_valid_o && ibi_byte_ready_i;
  assign ibi_req_o       = req_q;
  assign ibi_mdb_o       = desc_q.mdb;
  assign ibi_status_o    = status_q;
  assign ibi_status_we_o = status_we_q;
  assign busy_o          = (state_q != StIdle);

  ibi_byte_serializer #(
    .IbiDataWidth(IbiDataWidth),
    .LenWidth    (IbiLenWidth)
  ) u_serializer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (pop_start),
    .len_i      (desc_in.len),
    .load_i     (pop_send),
    .word_i     (ibi_queue_rdata_i),
    .clear_i    ((state_q == StSend) && ibi_abort_i),
    .ready_i    (ibi_byte_ready_i),
    .byte_o     (ibi_byte_o),
    .valid_o    (ibi_byte_valid_o),
    .last_o     (ibi_byte_last_o),
    .need_word_o(need_word)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      desc_q       <= '0;
      words_left_q <= '0;
      status_q     <= IbiStsOk;
      req_q        <= 1'b0;
      status_we_q  <= 1'b0;
`ifdef I3C_IBI_RETRY_EN
      retry_cnt_q  <= '0;
      delay_cnt_q  <= '0;
`endif
    end else begin
      // NOTE: non-blocking defaults followed by conditional overrides: the last
      // assignment in the block wins, so the write strobe is high exactly in
      // the cycle after it is set.
      status_we_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pop_start) begin
            desc_q       <= desc_in;
            words_left_q <= words_in;
            req_q        <= 1'b1;
            state_q      <= StReq;
`ifdef I3C_IBI_RETRY_EN
            retry_cnt_q  <= '0;
`endif
          end
        end
        StReq: begin
          // nack beats a simultaneous ack; an ack beats a falling enable since
          // the IBI is then already owned by the bus.
          if (ibi_nack_i) begin
            req_q <= 1'b0;
`ifdef I3C_IBI_RETRY_EN
            if (retry_cnt_q < RetryW'(MaxRetries)) begin
              retry_cnt_q <= retry_cnt_q + RetryW'(1);
              delay_cnt_q <= '0;
              state_q     <= StBackoff;
            end else begin
              status_q <= IbiStsNacked;
              state_q  <= StDrain;
            end
`else
            status_q <= IbiStsNacked;
            state_q  <= StDrain;
`endif
          end else if (ibi_ack_i) begin
            req_q <= 1'b0;
            if (desc_q.len == '0) begin
              status_q    <= IbiStsOk;
              status_we_q <= 1'b1;
              state_q     <= StStatus;
            end else begin
              state_q <= StSend;
            end
          end else if (!ibi_en_i) begin
            req_q    <= 1'b0;
            status_q <= IbiStsDisabled;
            state_q  <= StDrain;
          end
        end
`ifdef I3C_IBI_RETRY_EN
        StBackoff: begin
          if (!ibi_en_i) begin
            status_q <= IbiStsDisabled;
            state_q  <= StDrain;
          end else if (delay_cnt_q == DelayW'(RetryDelay - 1)) begin
            delay_cnt_q <= '0;
            req_q       <= 1'b1;
            state_q     <= StReq;
          end else begin
            delay_cnt_q <= delay_cnt_q + DelayW'(1);
          end
        end
`endif
        StSend: begin
          // ibi_en_i is deliberately not looked at: the transfer is on the bus.
          if (pop_send) words_left_q <= words_left_q - IbiLenWidth'(1);
          if (ibi_abort_i) begin
            status_q <= IbiStsAborted;
            state_q  <= StDrain;
          end else if (byte_hs && ibi_byte_last_o) begin
            status_q    <= IbiStsOk;
            status_we_q <= 1'b1;
            state_q     <= StStatus;
          end
        end
        StDrain: begin
          if (words_left_q == '0) begin
            status_we_q <= 1'b1;
            state_q     <= StStatus;
          end else if (pop_drain) begin
            words_left_q <= words_left_q - IbiLenWidth'(1);
          end
        end
        StStatus: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/tti_ibi_sequencer.md
# tti_ibi_sequencer

Sequences In-Band Interrupts on the target side. It pops IBI descriptors and payload words from the TTI IBI queue, checks that IBI is enabled, and requests the IBI from the target bus FSM. It retries on NACK, streams the payload bytes, and reports the outcome through the LAST_IBI_STATUS write port of the TTI. It sits between the IBI queue read side and the I3C target flow FSM.

## Interface
- IbiDataWidth, 32: IBI queue word width; must be a multiple of 8. BPW = IbiDataWidth/8 bytes per word.
- MaxRetries, 3: maximum NACK retries after the first attempt.
- RetryDelay, 16: backoff cycles between a NACK and the next request.
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- ibi_queue_empty_i  in  1  IBI queue empty
- ibi_queue_rdata_i  in  IbiDataWidth  head word; first-word fall-through, valid when not empty
- ibi_queue_rd_o  out  1  one-cycle pop strobe
- ibi_en_i  in  1  CONTROL.IBI_EN
- ibi_req_o  out  1  IBI request to the target FSM
- ibi_mdb_o  out  8  mandatory data byte of the current IBI
- ibi_ack_i  in  1  controller ACKed the IBI address
- ibi_nack_i  in  1  controller NACKed, or arbitration lost
- ibi_byte_o  out  8  payload byte
- ibi_byte_valid_o  out  1  payload byte valid
- ibi_byte_last_o  out  1  last payload byte
- ibi_byte_ready_i  in  1  FSM accepts the byte
- ibi_abort_i  in  1  controller ended the read early
- ibi_status_o  out  2  status value for LAST_IBI_STATUS
- ibi_status_we_o  out  1  one-cycle status write strobe
- busy_o  out  1  state is not IDLE

## Operation
- Descriptor word format:
  - [31:24] MDB.
  - [7:0] LEN, the payload byte count (0..255).
  - Remaining bits are ignored.
  - Followed by WORDS = ceil(LEN/BPW) payload words, least significant byte sent first.
- States: IDLE, REQ, BACKOFF, SEND, DRAIN, STATUS.
- IDLE:
  - If the queue is not empty and ibi_en_i=1: pop, latch MDB/LEN, set remaining words = WORDS, retry count = 0, go to REQ.
  - If IBI is disabled, the descriptor is held and not popped.
- REQ: ibi_req_o=1.
  - ack with LEN=0: go to STATUS with OK.
  - ack with LEN>0: go to SEND.
  - nack with retry count < MaxRetries: increment retry count, go to BACKOFF.
  - nack otherwise: go to DRAIN with NACKED.
  - ibi_en_i=0: drop ibi_req_o and go to DRAIN with DISABLED.
- BACKOFF: count RetryDelay cycles, then return to REQ. ibi_en_i=0 goes to DRAIN with DISABLED.
- SEND:
  - When the byte buffer is empty and a word is available, pop it into the shift buffer and decrement remaining words.
  - Present bytes in order. ibi_byte_last_o is high on byte LEN-1.
  - The final word's unused upper bytes are discarded.
  - If the queue is empty, valid stays low (stall) with no timeout.
  - Last byte accepted: go to STATUS with OK.
  - ibi_abort_i: go to DRAIN with ABORTED.
- DRAIN: pop the remaining words as they become available. When remaining words reaches 0, go to STATUS.
- STATUS: pulse ibi_status_we_o with the latched code, then go to IDLE.
- Status codes: OK=2'b00, NACKED=2'b01, ABORTED=2'b10, DISABLED=2'b11.
- Simultaneous events:
  - ack and nack together: nack wins.
  - abort with a byte handshake in the same cycle: the byte counts as sent, and abort wins.
  - ibi_en_i falling during SEND is ignored; the transfer is already on the bus.

## Timing
- Reset: every output is 0, state is IDLE, all counters are 0. An asynchronous reset mid-IBI discards the latched descriptor with no status write.
- Pop to ibi_req_o: 1 cycle.
- ibi_req_o holds until ack, nack, or disable.
- Byte stream uses valid/ready. Byte and valid are stable while ready=0.
- Back-to-back bytes: one per cycle, including across word boundaries. The next word is popped in the cycle the last byte of the current word is accepted.
- Last byte accepted to ibi_status_we_o: 1 cycle.
- Status to the next descriptor pop: minimum 1 cycle, because IDLE is entered before the next pop.

## Configuration
- I3C_IBI_RETRY_EN defined: NACK retry and BACKOFF behave as described above.
- I3C_IBI_RETRY_EN undefined:
  - The BACKOFF state and the retry and delay counters are removed.
  - The first nack goes to DRAIN with NACKED.
  - MaxRetries and RetryDelay are ignored.

## Structure
- Shared in i3c_pkg:
  - the ibi_status_e enum with the four codes;
  - the ibi_desc_t packed struct (mdb, len);
  - the IbiMdbOffset and IbiLenWidth constants.
- The FSM and counters live in tti_ibi_sequencer.
- One sub-module, ibi_byte_serializer, handles word load, byte select, and the last-byte flag.

## Test plan
- Descriptor 0xAE000005 followed by words 0x44332211 and 0x00000055, ack on first request: bytes 11 22 33 44 55 with last on 55; 3 pops; status 00.
- LEN=0 descriptor, ack: no byte valid; status 00 one cycle after ack.
- Three nacks then ack (retry enabled, MaxRetries=3): 3 BACKOFF periods of 16 cycles, then payload sent, status 00.
- Four nacks: status 01, payload words drained. With the macro off, the first nack gives 01.
- ibi_abort_i after byte 2 of an 8-byte IBI: both words popped, status 10.
- ibi_en_i=0 with the queue non-empty: no pop. ibi_en_i dropping during BACKOFF: drain, then status 11.
